bus_arbiter: RTL

Parametrised, clocked successor to the shared tristate data bus. N requesters compete for a single registered output channel. A round-robin arbiter with optional burst locking picks the winner, and a valid/ready handshake to the sink replaces static select lines. It sits between the datapath sources (ALU, memory read port, immediate generator, CSR read) and the register-file write-back port.

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_picker.sv | 33 +++
 rtl/bus_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus_arbiter slice.
package bus_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_SRC_DEF  = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Encode a one-hot (or zero) vector of up to 32 bits into its bit index.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: searches from ptr_i+1 upward, wrapping,
// so the source at ptr_i has the lowest priority.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // First requester found after the pointer wins.
    always_comb begin
        gnt_o = '0;
        cand  = '0;
        for (int off = 1; off <= N_SRC; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % N_SRC);
            if (gnt_o == '0 && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
            end
        end
    end

    assign idx_o = IDX_W'(onehot_to_idx(32'(gnt_o)));
    assign any_o = |gnt_o;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin N-source arbiter feeding one registered valid/ready channel.
// Optional burst locking is compiled in with BUS_ARBITER_LOCK_EN; without it
// the lock port is accepted but ignored.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int   DATA_W = DATA_W_DEF,
    parameter int   N_SRC  = N_SRC_DEF,
    localparam int  IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC-1:0]        lock,
    input  logic [N_SRC*DATA_W-1:0] data_lines,
    input  logic                    ready,
    output logic [N_SRC-1:0]        grant,
    output logic signed [DATA_W-1:0] bus_out,
    output logic                    bus_valid,
    output logic [IDX_W-1:0]        owner
);

    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_valid_q, bus_valid_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic              slot_free;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] lane [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_lane
        assign lane[g] = data_lines[g*DATA_W +: DATA_W];
    end

    assign slot_free = !bus_valid_q || ready;

`ifdef BUS_ARBITER_LOCK_EN
    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  lock_src_q, lock_src_d;

    // While locked only the lock holder may compete.
    assign eligible = (state_q == LOCKED) ? (req & (N_SRC'(1) << lock_src_q)) : req;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign eligible    = req;
`endif

    rr_picker #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign grant = slot_free ? pick_gnt : '0;

    // Next-state: capture the winner when the slot is free, drain otherwise.
    always_comb begin
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
`ifdef BUS_ARBITER_LOCK_EN
        state_d     = state_q;
        lock_src_d  = lock_src_q;
`endif
        if (slot_free) begin
            if (pick_any) begin
                bus_out_d   = lane[pick_idx];
                bus_valid_d = 1'b1;
                owner_d     = pick_idx;
                ptr_d       = pick_idx;
`ifdef BUS_ARBITER_LOCK_EN
                if (lock[pick_idx]) begin
                    state_d    = LOCKED;
                    lock_src_d = pick_idx;
                end else begin
                    state_d    = ARB;
                end
`endif
            end else begin
                // Free slot with nothing granted: either ready consumed the beat
                // or the slot was already empty.
                bus_valid_d = 1'b0;
`ifdef BUS_ARBITER_LOCK_EN
                // In LOCKED an empty pick means the holder dropped req.
                state_d = ARB;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= IDX_W'(N_SRC - 1);
`ifdef BUS_ARBITER_LOCK_EN
            state_q     <= ARB;
            lock_src_q  <= '0;
`endif
        end else begin
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
`ifdef BUS_ARBITER_LOCK_EN
            state_q     <= state_d;
            lock_src_q  <= lock_src_d;
`endif
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign owner     = owner_q;

endmodule
